// File: rtl/iir_pkg.sv
// Shared types and helpers for the serial all-pole IIR and related decimator stages.
package iir_pkg;

  typedef enum logic [1:0] {IDLE, MAC, OUT, HOLD} state_t;

  // Widest accumulator the saturating helper can take.
  localparam int SAT_W = 128;

  // Smallest accumulator that cannot overflow over one full recursion.
  function automatic int acc_width_min(input int bw, input int n);
    return 2*bw + $clog2(n) + 1;
  endfunction

  function automatic logic signed [SAT_W-1:0] sat_to_width(
    input logic signed [SAT_W-1:0] v, input int width);
    logic signed [SAT_W-1:0] hi, lo;
    hi = {{(SAT_W-1){1'b0}}, 1'b1} << (width-1);
    hi = hi - 1;
    lo = -hi - 1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/iir_allpole_serial_if.sv
// Sample-in / sample-out valid-ready bus of the serial all-pole IIR.
interface iir_allpole_serial_if #(parameter int BITWIDTH = 16) ();
  logic                       in_valid;
  logic                       in_ready;
  logic signed [BITWIDTH-1:0] inP;
  logic                       out_valid;
  logic                       out_ready;
  logic signed [BITWIDTH-1:0] outP;

  modport master (output in_valid, inP, out_ready, input in_ready, out_valid, outP);
  modport slave  (input in_valid, inP, out_ready, output in_ready, out_valid, outP);
endinterface

// File: rtl/iir_sat_shift.sv
// Accumulator to sample conversion: drop P fraction bits, then clamp to BITWIDTH.
// Build with IIR_ROUND_EN for round-half-up; default truncates toward -inf.
module iir_sat_shift
  import iir_pkg::*;
#(
  parameter int BITWIDTH = 16,
  parameter int ACCWIDTH = 40,
  parameter int P        = 14
) (
  input  logic signed [ACCWIDTH-1:0] acc,
  output logic signed [BITWIDTH-1:0] result
);

  logic signed [ACCWIDTH-1:0] biased, shifted;

`ifdef IIR_ROUND_EN
  if (P > 0) begin : g_rnd
    localparam logic signed [ACCWIDTH-1:0] HALF = ACCWIDTH'(1) << (P-1);
    assign biased = acc + HALF;
  end else begin : g_nornd
    assign biased = acc;
  end
`else
  assign biased = acc;
`endif

  assign shifted = biased >>> P;
  assign result  = BITWIDTH'(sat_to_width(SAT_W'(shifted), BITWIDTH));

endmodule

// File: rtl/iir_allpole_serial.sv
// Time-multiplexed all-pole IIR: y[n] = x[n] - sum a[k]*y[n-k] / 2^P, one MAC per cycle.
// Optional IIR_ROUND_EN selects round-half-up in the output conversion.
module iir_allpole_serial
  import iir_pkg::*;
#(
  parameter int BITWIDTH = 16,
  parameter int ACCWIDTH = 40,
  parameter int N        = 16,
  parameter int P        = 14
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       clear,
  input  logic signed [BITWIDTH-1:0] coeffs [N-1:0],
  iir_allpole_serial_if.slave        bus
);

  localparam int KW = $clog2(N);
  localparam logic [KW-1:0] KLAST = KW'(N-1);

  if (N < 2) begin : g_bad_n
    $error("iir_allpole_serial: N must be >= 2");
  end
  if (ACCWIDTH < acc_width_min(BITWIDTH, N) || ACCWIDTH > SAT_W) begin : g_bad_acc
    $error("iir_allpole_serial: ACCWIDTH out of range");
  end

  state_t                     state, state_nxt;
  logic                       alive;
  logic [KW-1:0]              k;
  logic signed [ACCWIDTH-1:0] acc;
  logic signed [BITWIDTH-1:0] hist [N-1:1];
  logic signed [BITWIDTH-1:0] tap;
  logic signed [2*BITWIDTH-1:0] prod;
  logic signed [BITWIDTH-1:0] y_sat;
  logic signed [BITWIDTH-1:0] outp_q;
  logic                       out_valid_q;
  logic                       accept;

  // alive keeps in_ready low until the first edge after reset release
  assign bus.in_ready  = alive && (state == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.outP      = outp_q;
  assign accept        = bus.in_valid && bus.in_ready && !clear;

  always_comb begin
    tap = '0;
    for (int i = 1; i < N; i++)
      if (k == KW'(i)) tap = hist[i];
  end

  assign prod = coeffs[k] * tap;

  iir_sat_shift #(.BITWIDTH(BITWIDTH), .ACCWIDTH(ACCWIDTH), .P(P)) u_sat (
    .acc    (acc),
    .result (y_sat)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = MAC;
      MAC:  if (k == KLAST) state_nxt = OUT;
      OUT:  state_nxt = HOLD;
      HOLD: if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (clear) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      alive <= 1'b0;
    end else begin
      state <= state_nxt;
      alive <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      acc         <= '0;
      k           <= '0;
      out_valid_q <= 1'b0;
      outp_q      <= '0;
      for (int i = 1; i < N; i++) hist[i] <= '0;
    end else if (clear) begin
      acc         <= '0;
      k           <= '0;
      out_valid_q <= 1'b0;
      for (int i = 1; i < N; i++) hist[i] <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          acc <= ACCWIDTH'(bus.inP) <<< P;
          k   <= KW'(1);
        end
        MAC: begin
          acc <= acc - ACCWIDTH'(prod);
          k   <= (k == KLAST) ? '0 : k + 1'b1;
        end
        OUT: begin
          // feedback history always takes the clamped sample
          outp_q      <= y_sat;
          out_valid_q <= 1'b1;
          for (int i = 2; i < N; i++) hist[i] <= hist[i-1];
          hist[1] <= y_sat;
        end
        HOLD: if (bus.out_ready) out_valid_q <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iir_allpole_serial.sv
// Directed bench for iir_allpole_serial at N=4, P=14, BITWIDTH=16.
module tb_iir_allpole_serial;

  logic clk, resetn, clear;
  logic signed [15:0] coeffs [3:0];
  int nvec, nerr;

  iir_allpole_serial_if #(.BITWIDTH(16)) bus ();

  iir_allpole_serial #(.BITWIDTH(16), .ACCWIDTH(40), .N(4), .P(14)) dut (
    .clk    (clk),
    .resetn (resetn),
    .clear  (clear),
    .coeffs (coeffs),
    .bus    (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clr();
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
  endtask

  task automatic set_a1(input int a1);
    for (int i = 0; i < 4; i++) coeffs[i] = '0;
    coeffs[1] = 16'(a1);
  endtask

  // offer one sample, check accept-to-valid latency and the output value
  task automatic run(input string tag, input int x, input int exp);
    int t;
    t = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.inP = 16'(x);
    while (!bus.in_ready && t < 100) begin @(negedge clk); t++; end
    if (!bus.in_ready) begin
      chk({tag, "_accept_timeout"}, 0, 1);
      bus.in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    t = 0;
    while (!bus.out_valid && t < 100) begin @(negedge clk); t++; end
    chk({tag, "_lat"}, t, 4);
    chk({tag, "_y"}, bus.outP, exp);
  endtask

  initial begin
    int t;
    nvec = 0; nerr = 0;
    resetn = 1'b0; clear = 1'b0;
    bus.in_valid = 1'b0; bus.inP = '0; bus.out_ready = 1'b1;
    set_a1(0);

    #12;
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_outP", bus.outP, 0);
    @(negedge clk); resetn = 1'b1;
    #1 chk("rel_in_ready_low", bus.in_ready, 0);
    @(negedge clk);
    chk("rel_in_ready_high", bus.in_ready, 1);

    // identity
    run("id0", 1000, 1000);
    run("id1", -7, -7);
    run("id2", 32767, 32767);

    // decay
    clr(); set_a1(-8192);
    run("dec0", 16384, 16384);
    run("dec1", 0, 8192);
    run("dec2", 0, 4096);
    run("dec3", 0, 2048);

    // saturation, history keeps clamped value
    clr(); set_a1(-16384);
    run("sat0", 30000, 30000);
    run("sat1", 30000, 32767);
    run("sat2", -10000, 22767);

    // backpressure
    clr(); set_a1(0);
    bus.out_ready = 1'b0;
    @(negedge clk); bus.in_valid = 1'b1; bus.inP = 16'sd5;
    t = 0;
    while (!bus.in_ready && t < 100) begin @(negedge clk); t++; end
    @(negedge clk); bus.inP = 16'sd9;
    t = 0;
    while (!bus.out_valid && t < 100) begin @(negedge clk); t++; end
    chk("bp_first", bus.outP, 5);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_outP_stable", bus.outP, 5);
      chk("bp_in_ready_low", bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", bus.out_valid, 0);
    chk("bp_release_idle", bus.in_ready, 1);
    @(negedge clk); bus.in_valid = 1'b0;
    t = 0;
    while (!bus.out_valid && t < 100) begin @(negedge clk); t++; end
    chk("bp_second", bus.outP, 9);

    // abort by reset mid-MAC
    clr(); set_a1(-8192);
    run("abA_pre", 16384, 16384);
    @(negedge clk); bus.in_valid = 1'b1; bus.inP = '0;
    t = 0;
    while (!bus.in_ready && t < 100) begin @(negedge clk); t++; end
    @(negedge clk); bus.in_valid = 1'b0;
    @(negedge clk);
    resetn = 1'b0;
    #1;
    chk("abA_valid", bus.out_valid, 0);
    chk("abA_in_ready", bus.in_ready, 0);
    @(negedge clk); resetn = 1'b1;
    run("abA_post", 0, 0);

    // abort by clear in HOLD
    clr();
    bus.out_ready = 1'b0;
    run("abB_pre", 16384, 16384);
    clear = 1'b1;
    @(negedge clk);
    chk("abB_valid", bus.out_valid, 0);
    clear = 1'b0; bus.out_ready = 1'b1;
    run("abB_post", 0, 0);

    // sample offered alongside clear is dropped
    @(negedge clk);
    clear = 1'b1; bus.in_valid = 1'b1; bus.inP = 16'sd100;
    @(negedge clk);
    clear = 1'b0; bus.in_valid = 1'b0;
    t = 0;
    repeat (8) begin @(negedge clk); if (bus.out_valid) t++; end
    chk("clr_drop", t, 0);

    // rounding
    clr(); set_a1(-8192);
    run("rnd_p0", 3, 3);
`ifdef IIR_ROUND_EN
    run("rnd_p1", 0, 2);
`else
    run("rnd_p1", 0, 1);
`endif
    clr();
    run("rnd_n0", -3, -3);
`ifdef IIR_ROUND_EN
    run("rnd_n1", 0, -1);
`else
    run("rnd_n1", 0, -2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
